// File: rtl/fwd_select_ctrl.sv
// rtl/fwd_select_ctrl.sv - EX-stage operand forwarding selects and load-use stall control
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears every slot and the stall counter
//   id_rs/id_rt   source register indices of the instruction in ID
//   id_uses_rt    ID instruction reads rt as an operand
//   id_rd         write destination of the ID instruction (already rt/rd muxed)
//   id_reg_write  ID instruction writes the register file
//   id_mem_read   ID instruction is a load
//   flush         taken branch/jump; the ID instruction becomes a bubble
//   fwd_a_sel     operand-A mux select: 00 regfile, 01 WB data, 10 MEM ALU result
//   fwd_b_sel     operand-B mux select, same encoding, forced to 00 when rt is unused
//   stall         load-use hazard: hold PC and IF/ID, bubble into EX
//   stall_cnt     saturating count of stall cycles since reset

module fwd_select_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // EX slot
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_uses_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_rw;
  logic              ex_mr;

  // MEM and WB slots only need the write destination
  logic [REG_AW-1:0] mem_rd;
  logic              mem_rw;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_rw;

  logic [CNT_W-1:0]  cnt_q;
  logic              bubble;

  // A single bubble covers both a stall and a flush landing on the same edge.
  assign bubble = stall | flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_uses_rt <= 1'b0;
      ex_rd      <= '0;
      ex_rw      <= 1'b0;
      ex_mr      <= 1'b0;
      mem_rd     <= '0;
      mem_rw     <= 1'b0;
      wb_rd      <= '0;
      wb_rw      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wb_rd  <= mem_rd;
      wb_rw  <= mem_rw;
      mem_rd <= ex_rd;
      mem_rw <= ex_rw;
      if (bubble) begin
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_uses_rt <= 1'b0;
        ex_rd      <= '0;
        ex_rw      <= 1'b0;
        ex_mr      <= 1'b0;
      end else begin
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_uses_rt <= id_uses_rt;
        ex_rd      <= id_rd;
        ex_rw      <= id_reg_write;
        ex_mr      <= id_mem_read;
      end
      if (stall && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Forwarding: MEM result is younger than WB data, so it wins when both match.
  // $0 is hard-wired to zero and is never a forwarding source.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;

    if (mem_rw && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      fwd_a_sel = SEL_MEM;
    end else if (wb_rw && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      fwd_a_sel = SEL_WB;
    end

    if (ex_uses_rt) begin
      if (mem_rw && (mem_rd != '0) && (mem_rd == ex_rt)) begin
        fwd_b_sel = SEL_MEM;
      end else if (wb_rw && (wb_rd != '0) && (wb_rd == ex_rt)) begin
        fwd_b_sel = SEL_WB;
      end
    end
  end

  // Load in EX whose result is needed by ID: the data only exists after MEM,
  // so ID waits one cycle. The bubble clears ex_mr, so this self-terminates.
  always_comb begin
    stall = 1'b0;
    if (ex_mr && (ex_rd != '0)) begin
      if ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt))) begin
        stall = 1'b1;
      end
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// tb/tb_fwd_select_ctrl.sv - directed bench for fwd_select_ctrl

module tb_fwd_select_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fwd_select_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic id_set(input int rs, input int rt, input int ut, input int rd,
                        input int rw, input int mr, input int fl);
    id_rs        = rs[REG_AW-1:0];
    id_rt        = rt[REG_AW-1:0];
    id_uses_rt   = ut[0];
    id_rd        = rd[REG_AW-1:0];
    id_reg_write = rw[0];
    id_mem_read  = mr[0];
    flush        = fl[0];
  endtask

  task automatic nop();
    id_set(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: reset held with a load that would otherwise stall/forward
    reset = 1'b1;
    id_set(3, 3, 1, 3, 1, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel_a", fwd_a_sel, 2'b00);
    check("rst_sel_b", fwd_b_sel, 2'b00);
    check("rst_stall", stall, 1'b0);
    check("rst_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nop();
    tick();

    // T2: add $3,$1,$2 ; sub $4,$3,$3
    id_set(1, 2, 1, 3, 1, 0, 0);
    tick();
    id_set(3, 3, 1, 4, 1, 0, 0);
    @(negedge clk);
    check("t2_no_stall", stall, 1'b0);
    tick();
    @(negedge clk);
    check("t2_sel_a", fwd_a_sel, 2'b10);
    check("t2_sel_b", fwd_b_sel, 2'b10);
    nop();
    repeat (3) tick();

    // T3: add $5 ; add $5 ; or $6,$5,$0
    id_set(1, 2, 1, 5, 1, 0, 0);
    tick();
    id_set(1, 2, 1, 5, 1, 0, 0);
    tick();
    id_set(5, 0, 1, 6, 1, 0, 0);
    tick();
    @(negedge clk);
    check("t3_sel_a_mem_wins", fwd_a_sel, 2'b10);
    check("t3_sel_b_r0", fwd_b_sel, 2'b00);

    // WB-only forward: add $7 ; nop ; and $8,$7,$7
    id_set(1, 2, 1, 7, 1, 0, 0);
    tick();
    nop();
    tick();
    id_set(7, 7, 1, 8, 1, 0, 0);
    tick();
    @(negedge clk);
    check("t3_wb_sel_a", fwd_a_sel, 2'b01);
    check("t3_wb_sel_b", fwd_b_sel, 2'b01);

    // rt not used: addi $11,$10 with rt field = 10
    id_set(1, 2, 1, 10, 1, 0, 0);
    tick();
    id_set(10, 10, 0, 11, 1, 0, 0);
    tick();
    @(negedge clk);
    check("t3_nouse_sel_a", fwd_a_sel, 2'b10);
    check("t3_nouse_sel_b", fwd_b_sel, 2'b00);
    nop();
    repeat (3) tick();

    // T4: lw $8 ; add $9,$8,$2
    id_set(1, 8, 0, 8, 1, 1, 0);
    tick();
    id_set(8, 2, 1, 9, 1, 0, 0);
    @(negedge clk);
    check("t4_stall", stall, 1'b1);
    tick();
    @(negedge clk);
    check("t4_stall_one_cycle", stall, 1'b0);
    check("t4_cnt", stall_cnt, 1);
    check("t4_bubble_sel_a", fwd_a_sel, 2'b00);
    tick();
    @(negedge clk);
    check("t4_sel_a_wb", fwd_a_sel, 2'b01);
    check("t4_sel_b", fwd_b_sel, 2'b00);

    // load-use through rt, only when rt is actually read
    nop();
    tick();
    id_set(1, 12, 0, 12, 1, 1, 0);
    tick();
    id_set(1, 12, 0, 13, 1, 0, 0);
    @(negedge clk);
    check("t4_rt_unused_no_stall", stall, 1'b0);
    id_set(1, 12, 1, 13, 1, 0, 0);
    #1;
    check("t4_rt_stall", stall, 1'b1);
    tick();
    @(negedge clk);
    check("t4_rt_cnt", stall_cnt, 2);
    check("t4_rt_stall_clear", stall, 1'b0);
    nop();
    repeat (3) tick();

    // T5: writes to $0 are never forwarded or stalled on
    id_set(1, 2, 1, 0, 1, 0, 0);
    tick();
    id_set(0, 0, 1, 4, 1, 0, 0);
    tick();
    @(negedge clk);
    check("t5_r0_sel_a", fwd_a_sel, 2'b00);
    check("t5_r0_sel_b", fwd_b_sel, 2'b00);
    id_set(1, 0, 0, 0, 1, 1, 0);
    tick();
    id_set(0, 0, 1, 5, 1, 0, 0);
    @(negedge clk);
    check("t5_r0_no_stall", stall, 1'b0);
    tick();

    // flushed load leaves no trace
    id_set(1, 13, 0, 13, 1, 1, 1);
    tick();
    id_set(13, 13, 1, 14, 1, 0, 0);
    @(negedge clk);
    check("t5_flush_no_stall", stall, 1'b0);
    tick();
    @(negedge clk);
    check("t5_flush_sel_a", fwd_a_sel, 2'b00);
    check("t5_flush_sel_b", fwd_b_sel, 2'b00);

    // flush and stall together still count
    nop();
    tick();
    id_set(1, 15, 0, 15, 1, 1, 0);
    tick();
    id_set(15, 1, 1, 16, 1, 0, 1);
    @(negedge clk);
    check("t5_fs_stall", stall, 1'b1);
    tick();
    @(negedge clk);
    check("t5_fs_cnt", stall_cnt, 3);
    check("t5_fs_bubble", stall, 1'b0);
    nop();
    repeat (3) tick();

    // T6: 20 more load-use pairs, counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      id_set(1, 8, 0, 8, 1, 1, 0);
      tick();
      id_set(8, 2, 1, 9, 1, 0, 0);
      @(negedge clk);
      check($sformatf("t6_stall_%0d", i), stall, 1'b1);
      tick();
      tick();
    end
    @(negedge clk);
    check("t6_cnt_sat", stall_cnt, 15);

    // async reset between edges while a stall and forward are live
    id_set(1, 8, 0, 8, 1, 1, 0);
    tick();
    id_set(8, 8, 1, 9, 1, 0, 0);
    @(negedge clk);
    check("t6_pre_rst_stall", stall, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_cnt", stall_cnt, 0);
    check("t6_async_stall", stall, 1'b0);
    check("t6_async_sel_a", fwd_a_sel, 2'b00);
    check("t6_async_sel_b", fwd_b_sel, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nop();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
